// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared types and constants for the data bus control initiator
package data_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_GRANT,
        ST_ACK
    } state_t;

    localparam int OP_LSB   = 6;
    localparam int SRC_LSB  = 4;
    localparam int DEST_LSB = 2;

    localparam logic [1:0] CTRL_ID_DEFAULT = 2'b11;
    localparam int PREAMBLE_BYTES = 3;

    function automatic logic [7:0] make_header(
        input logic [1:0] op,
        input logic [1:0] src,
        input logic [1:0] dest
    );
        logic [7:0] h;
        h = '0;
        h[OP_LSB +: 2]   = op;
        h[SRC_LSB +: 2]  = src;
        h[DEST_LSB +: 2] = dest;
        return h;
    endfunction

endpackage

// File: rtl/data_bus_timeout.sv
// data_bus_timeout: saturating 16-bit idle counter that flags the idle cycle reaching the limit
module data_bus_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count;

    // count idle cycles, clearing takes priority and the count never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && count != 16'hFFFF)
            count <= count + 16'd1;
    end

    assign expired = en && !clr && count >= LAST;

endmodule

// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: drives the 3-byte preamble, grants the bus to the source and closes with ack
module data_bus_ctrl
    import data_bus_pkg::*;
#(
    parameter logic [1:0] CTRL_ID        = CTRL_ID_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_src,
    input  logic [1:0]  cmd_dest,
    input  logic [15:0] cmd_len,
    output logic [7:0]  bus_data_o,
    output logic        bus_valid_o,
    output logic        bus_oe,
    input  logic [7:0]  bus_data_i,
    input  logic        bus_valid_i,
    output logic        ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      state, nxt;
    logic [15:0] len_q, remaining;
    logic        fail, reject, collide, expired, tmo_clr, tmo_en, pre_nxt;
    logic [7:0]  data_nxt;
    logic        unused_data;

    assign unused_data = ^bus_data_i;
    assign collide  = bus_valid_i && !bus_oe && (state inside {ST_HDR, ST_LEN_HI, ST_LEN_LO});
    assign tmo_clr  = state == ST_LEN_LO || (state == ST_GRANT && bus_valid_i);
    assign tmo_en   = state == ST_GRANT && !bus_valid_i;
    assign pre_nxt  = nxt inside {ST_HDR, ST_LEN_HI, ST_LEN_LO};
    assign data_nxt = nxt == ST_HDR    ? make_header(cmd_op, cmd_src, cmd_dest) :
                      nxt == ST_LEN_HI ? len_q[15:8] :
                      nxt == ST_LEN_LO ? len_q[7:0]  : 8'h00;

    data_bus_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (expired)
    );

    // next-state decode; fail marks an abnormal entry into ACK
    always_comb begin
        nxt    = state;
        fail   = 1'b0;
        reject = 1'b0;
        case (state)
            ST_IDLE: begin
                reject = cmd_valid && (cmd_src == CTRL_ID || cmd_src == cmd_dest);
                nxt    = cmd_valid && !reject ? ST_HDR : ST_IDLE;
            end
            ST_HDR: begin
                fail = collide;
                nxt  = collide ? ST_ACK : ST_LEN_HI;
            end
            ST_LEN_HI: begin
                fail = collide;
                nxt  = collide ? ST_ACK : ST_LEN_LO;
            end
            ST_LEN_LO: begin
                fail = collide;
                nxt  = collide || len_q == 16'd0 ? ST_ACK : ST_GRANT;
            end
            ST_GRANT: begin
                fail = !bus_valid_i && expired;
                nxt  = (bus_valid_i && remaining == 16'd1) || fail ? ST_ACK : ST_GRANT;
            end
            ST_ACK:  nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // state register and command length capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            len_q <= '0;
        end else begin
            state <= nxt;
            if (state == ST_IDLE && cmd_valid)
                len_q <= cmd_len;
        end
    end

    // payload bytes still owed by the source; stops at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            remaining <= '0;
        else if (state == ST_LEN_LO && nxt == ST_GRANT)
            remaining <= len_q;
        else if (state == ST_GRANT && bus_valid_i && remaining != 16'd0)
            remaining <= remaining - 16'd1;
    end

    // outputs are registered from the upcoming state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            bus_oe      <= 1'b0;
            bus_valid_o <= 1'b0;
            bus_data_o  <= 8'h00;
            ack         <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            cmd_ready   <= nxt == ST_IDLE;
            busy        <= nxt != ST_IDLE;
            bus_oe      <= pre_nxt;
            bus_valid_o <= pre_nxt;
            bus_data_o  <= data_nxt;
            ack         <= nxt == ST_ACK;
            done        <= nxt == ST_ACK && !fail;
            err         <= reject || (nxt == ST_ACK && fail);
        end
    end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// tb_data_bus_ctrl: table-driven check of preamble, payload counting, reject, timeout, collision and reset
module tb_data_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0, cmd_src = '0, cmd_dest = '0;
    logic [15:0] cmd_len = '0;
    logic [7:0]  bus_data_o;
    logic        bus_valid_o, bus_oe;
    logic [7:0]  bus_data_i = '0;
    logic        bus_valid_i = 1'b0;
    logic        ack, busy, done, err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    data_bus_ctrl #(.CTRL_ID(2'b11), .TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_src     (cmd_src),
        .cmd_dest    (cmd_dest),
        .cmd_len     (cmd_len),
        .bus_data_o  (bus_data_o),
        .bus_valid_o (bus_valid_o),
        .bus_oe      (bus_oe),
        .bus_data_i  (bus_data_i),
        .bus_valid_i (bus_valid_i),
        .ack         (ack),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // expected word: {ready, oe, valid_o, data[7:0], ack, busy, done, err}
    typedef struct packed {
        logic        cv;
        logic [1:0]  op;
        logic [1:0]  src;
        logic [1:0]  dest;
        logic [15:0] len;
        logic        bv;
        logic [14:0] exp;
    } vec_t;

    localparam logic [14:0] IDLE_O = {3'b100, 8'h00, 4'b0000};
    localparam logic [14:0] GR     = {3'b000, 8'h00, 4'b0100};
    localparam logic [14:0] ACKD   = {3'b000, 8'h00, 4'b1110};
    localparam logic [14:0] ACKE   = {3'b000, 8'h00, 4'b1101};
    localparam logic [14:0] REJ    = {3'b100, 8'h00, 4'b0001};

    function automatic logic [14:0] pre(input logic [7:0] d);
        return {3'b011, d, 4'b0100};
    endfunction

    function automatic vec_t vec(input logic cv, input logic [1:0] op, input logic [1:0] src,
                                 input logic [1:0] dest, input logic [15:0] len, input logic bv,
                                 input logic [14:0] exp);
        vec_t t;
        t.cv = cv; t.op = op; t.src = src; t.dest = dest; t.len = len; t.bv = bv; t.exp = exp;
        return t;
    endfunction

    function automatic vec_t w(input logic bv, input logic [14:0] exp);
        return vec(1'b0, 2'd0, 2'd0, 2'd0, 16'd0, bv, exp);
    endfunction

    function automatic logic [14:0] outs();
        return {cmd_ready, bus_oe, bus_valid_o, bus_data_o, ack, busy, done, err};
    endfunction

    task automatic check(input string name, input logic [14:0] want);
        logic [14:0] got, m;
        got = outs();
        m = want[13] ? 15'h7FFF : 15'h700F;
        total++;
        if ((got & m) !== (want & m)) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (ready,oe,vo,data,ack,busy,done,err)", name, got, want);
        end
    endtask

    task automatic apply(input vec_t t, input string name);
        cmd_valid   = t.cv;
        cmd_op      = t.op;
        cmd_src     = t.src;
        cmd_dest    = t.dest;
        cmd_len     = t.len;
        bus_valid_i = t.bv;
        bus_data_i  = t.bv ? 8'hA5 : 8'h00;
        @(negedge clk);
        check(name, t.exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        // normal transfer, 4 payload bytes with gaps; valid seen during preamble is our own drive
        tbl.push_back(vec(1'b1, 2'd1, 2'd1, 2'd2, 16'd4, 1'b0, pre(8'h58)));
        tbl.push_back(w(1'b1, pre(8'h00)));
        tbl.push_back(w(1'b1, pre(8'h04)));
        tbl.push_back(w(1'b1, GR));
        tbl.push_back(w(1'b1, GR));
        tbl.push_back(w(1'b0, GR));
        tbl.push_back(w(1'b1, GR));
        tbl.push_back(w(1'b1, GR));
        tbl.push_back(w(1'b0, GR));
        tbl.push_back(w(1'b1, ACKD));
        tbl.push_back(w(1'b1, IDLE_O));
        tbl.push_back(w(1'b1, IDLE_O));
        // zero-length transfer goes straight from LEN_LO to ACK
        tbl.push_back(vec(1'b1, 2'd0, 2'd0, 2'd1, 16'd0, 1'b0, pre(8'h04)));
        tbl.push_back(w(1'b0, pre(8'h00)));
        tbl.push_back(w(1'b0, pre(8'h00)));
        tbl.push_back(w(1'b0, ACKD));
        tbl.push_back(w(1'b0, IDLE_O));
        // rejects: source is the control unit, source equals destination
        tbl.push_back(vec(1'b1, 2'd0, 2'd3, 2'd0, 16'd5, 1'b0, REJ));
        tbl.push_back(w(1'b0, IDLE_O));
        tbl.push_back(vec(1'b1, 2'd2, 2'd2, 2'd2, 16'd5, 1'b0, REJ));
        tbl.push_back(w(1'b0, IDLE_O));

        repeat (2) @(negedge clk);
        check("reset", IDLE_O);
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // timeout: one byte, byte arriving on the would-be timeout cycle, then 8 idle cycles
        apply(vec(1'b1, 2'd2, 2'd1, 2'd0, 16'd3, 1'b0, pre(8'h90)), "to_hdr");
        apply(w(1'b0, pre(8'h00)), "to_lhi");
        apply(w(1'b0, pre(8'h03)), "to_llo");
        apply(w(1'b0, GR), "to_grant");
        apply(w(1'b1, GR), "to_byte1");
        for (int i = 1; i <= 7; i++)
            apply(w(1'b0, GR), $sformatf("to_idle_a%0d", i));
        apply(w(1'b1, GR), "to_byte_wins");
        for (int i = 1; i <= 7; i++)
            apply(w(1'b0, GR), $sformatf("to_idle_b%0d", i));
        apply(w(1'b0, ACKE), "to_expire");
        apply(w(1'b0, IDLE_O), "to_back_idle");

        // collision: another agent's valid while our enable is forced off in LEN_HI
        apply(vec(1'b1, 2'd1, 2'd2, 2'd0, 16'h0102, 1'b0, pre(8'h60)), "col_hdr");
        apply(w(1'b0, pre(8'h01)), "col_lhi");
        force dut.bus_oe = 1'b0;
        bus_valid_i = 1'b1;
        @(negedge clk);
        release dut.bus_oe;
        check("col_abort", ACKE);
        apply(w(1'b0, IDLE_O), "col_idle");

        // asynchronous reset in GRANT, then a normal 1-byte transfer
        apply(vec(1'b1, 2'd0, 2'd1, 2'd3, 16'd5, 1'b0, pre(8'h1C)), "rst_hdr");
        apply(w(1'b0, pre(8'h00)), "rst_lhi");
        apply(w(1'b0, pre(8'h05)), "rst_llo");
        apply(w(1'b0, GR), "rst_grant");
        apply(w(1'b1, GR), "rst_byte");
        #2 rst_n = 1'b0;
        bus_valid_i = 1'b0;
        #1 check("rst_async", IDLE_O);
        @(negedge clk);
        check("rst_hold", IDLE_O);
        rst_n = 1'b1;
        apply(vec(1'b1, 2'd3, 2'd2, 2'd1, 16'd1, 1'b0, pre(8'hE4)), "post_hdr");
        apply(w(1'b0, pre(8'h00)), "post_lhi");
        apply(w(1'b0, pre(8'h01)), "post_llo");
        apply(w(1'b0, GR), "post_grant");
        apply(w(1'b1, ACKD), "post_ack");
        apply(w(1'b0, IDLE_O), "post_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_bus_ctrl.md
# data_bus_ctrl

Control-side initiator for the shared 8-bit data bus. It takes a transfer command from the control unit and puts a 3-byte preamble on the bus: header, then length high byte, then length low byte. It then hands bus ownership to the named source, counts the payload bytes the source drives, and ends the transaction with a one-cycle `ack` to every `data_bus` agent. Instantiated once per bus, beside the control unit's `data_bus` port (ID 2'b11).

## Interface
Parameters:
- `CTRL_ID`, 2'b11: agent ID of the control unit. A command whose source equals `CTRL_ID` is illegal.
- `TIMEOUT_CYCLES`, 1024: idle cycles in GRANT before the transfer is aborted. Range 2..65535.

Ports (single clock domain, `clk`; `rst_n` is asynchronous, active-low):
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: opcode, copied to header[7:6].
- `cmd_src` in 2: source agent ID, copied to header[5:4].
- `cmd_dest` in 2: destination agent ID, copied to header[3:2].
- `cmd_len` in 16: payload byte count.
- `bus_data_o` out 8: bus data driven by this block.
- `bus_valid_o` out 1: bus valid driven by this block.
- `bus_oe` out 1: tri-state enable for `bus_data_o` and `bus_valid_o`; the top level builds the buffer.
- `bus_data_i` in 8: resolved bus data.
- `bus_valid_i` in 1: resolved bus valid.
- `ack` out 1: end-of-transaction pulse, broadcast to all agents.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a transfer completes normally.
- `err` out 1: one-cycle pulse on reject, collision or timeout.

## Operation
- Header byte = {`cmd_op`, `cmd_src`, `cmd_dest`, 2'b00}.
- States are IDLE, HDR, LEN_HI, LEN_LO, GRANT, ACK.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch all command fields.
  - If `cmd_src`==`CTRL_ID` or `cmd_src`==`cmd_dest`: pulse `err`, stay in IDLE, no bus activity.
  - Otherwise go to HDR.
- HDR, LEN_HI, LEN_LO:
  - `bus_oe`=1, `bus_valid_o`=1.
  - `bus_data_o` = header, then `len[15:8]`, then `len[7:0]`.
- Collision: `bus_valid_i`=1 sampled while `bus_oe`=0 in HDR..LEN_LO means another agent is driving. Go to ACK with `err` set.
- LEN_LO exit:
  - `len`==0: go directly to ACK, normal completion.
  - Otherwise: load `remaining`=`len`, clear the idle counter, go to GRANT.
- GRANT:
  - `bus_oe`=0; the source owns the bus.
  - Each cycle with `bus_valid_i`=1: `remaining` decrements and the idle counter clears.
  - The decrement that reaches 0 moves the FSM to ACK.
  - A cycle with `bus_valid_i`=0 increments the idle counter. When it reaches `TIMEOUT_CYCLES`, go to ACK with `err`.
  - Extra bus bytes beyond `len` are never counted.
- ACK:
  - `ack`=1 for exactly one cycle.
  - `done`=1 in the same cycle if no error, otherwise `err`=1.
  - Next state is IDLE.
- `bus_data_i` is not interpreted; it is reserved for future checksum use.
- Arithmetic: `remaining` and the idle counter are 16 bits. Neither wraps: `remaining` never decrements below 0 and the idle counter saturates.

## Timing
- Command accepted at edge T (`cmd_valid`&&`cmd_ready`):
  - Header on bus in cycle T+1.
  - `len_hi` in T+2.
  - `len_lo` in T+3.
  - GRANT from T+4, with `bus_oe` low from T+4.
- Last payload byte seen at edge X: `ack` and `done` high in cycle X+1; `cmd_ready` high again in X+2.
- `len`==0: `ack` in T+4, `cmd_ready` in T+5.
- Reject: `err` in T+1; `cmd_ready` stays high throughout.
- All outputs are registered.
- Reset values: `cmd_ready`=1, all other outputs 0, `bus_oe`=0 (bus released), state IDLE.
- Reset asserted mid-transfer: bus released immediately (async) and no `ack` is issued. Agents are reset by the same `rst_n`.
- `bus_valid_i` and a timeout on the same cycle: the byte wins and the idle counter clears.

## Structure
- Package `data_bus_pkg`:
  - state enum;
  - header field positions (OP 7:6, SRC 5:4, DEST 3:2);
  - `CTRL_ID` default;
  - `PREAMBLE_BYTES`=3.
- One sub-module, `data_bus_timeout`: a saturating 16-bit idle counter with clear, count enable and an `expired` output.
- The FSM, preamble mux and `remaining` counter live in the top module.

## Test plan
- Normal transfer: op=1, src=2'b01, dest=2'b10, len=4; source drives 4 bytes with gaps.
  - Bus shows 0x58, 0x00, 0x04.
  - `ack` and `done` one cycle after the 4th byte.
- len=0, src=0, dest=1: preamble 0x04,0x00,0x00, then `ack` in T+4, no GRANT cycles.
- Reject: src=2'b11 -> `err` in T+1, `bus_oe` never high, `busy` stays 0.
  - src==dest -> same response.
- Timeout with `TIMEOUT_CYCLES`=8 and len=3:
  - Source drives 1 byte then stops.
  - `ack` and `err` 8 idle cycles later; `done` stays 0.
- Collision: `bus_valid_i` forced high during LEN_HI while `bus_oe`=0 (forced case) -> abort with `ack` and `err`.
- Async reset during GRANT: `bus_oe`=0 and `busy`=0 immediately, no `ack`; the next command completes normally.
